// File: rtl/tis_pkg.sv
// Shared TIS-100 fabric definitions: word width, port count, index and
// state types, and a one-hot helper used by the stack node.
package tis_pkg;

  localparam int WORD_W    = 11;
  localparam int NUM_PORTS = 4;
  // Entry count width; holds 0..15, which covers the largest stack depth.
  localparam int CNT_W     = 4;

  typedef logic signed [WORD_W-1:0] word_t;
  typedef logic [1:0]               port_idx_t;
  typedef logic [CNT_W-1:0]         cnt_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    CHECK = 2'd2
  } t30_state_t;

  // One-hot port mask for a port index.
  function automatic logic [NUM_PORTS-1:0] onehot(input port_idx_t idx);
    logic [NUM_PORTS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/stack_mem.sv
// LIFO storage for the stack node: word array plus entry count.
// push writes at count, pop drops the top, push+pop replaces the top
// in place and leaves the count unchanged. The caller guarantees no
// push when full (unless popping) and no pop when empty.
module stack_mem
  import tis_pkg::*;
#(
  parameter int DEPTH = 15
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  push,
  input  logic  pop,
  input  word_t wdata,
  output cnt_t  count,
  output word_t top,
  output word_t below
);

  word_t mem_q [DEPTH];
  cnt_t  count_q;
  cnt_t  count_d;
  cnt_t  wr_idx;

  // Next count and write slot for push / pop / replace.
  always_comb begin
    count_d = count_q;
    wr_idx  = count_q;
    if (push && pop) begin
      wr_idx = count_q - cnt_t'(1);
    end else if (push) begin
      count_d = count_q + cnt_t'(1);
    end else if (pop) begin
      count_d = count_q - cnt_t'(1);
    end
  end

  // Entry count; reset empties the stack logically.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  // Word array has no reset; contents above count are don't-care.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_idx] <= wdata;
  end

  // Top and the entry beneath it (the new top after a plain pop).
  always_comb begin
    top   = '0;
    below = '0;
    if (count_q != '0)       top   = mem_q[count_q - cnt_t'(1)];
    if (count_q >= cnt_t'(2)) below = mem_q[count_q - cnt_t'(2)];
  end

  assign count = count_q;

endmodule

// File: rtl/node_t30.sv
// TIS-100 stack-memory node (T30). Responder on four neighbour ports:
// accepts one pushed word per cycle (lowest ready port wins) and offers
// the top to one reader at a time in round-robin OFFER/CHECK pairs.
// Handshake: a writer holds ready[i] with data on in_i until it sees a
// one-cycle recv[i]; a reader sees send[i] for one cycle, captures
// outData, and pulses done[i] in the following cycle to take the word.
// Optional macro T30_LEVEL_EN adds the level output (current count).
module node_t30
  import tis_pkg::*;
#(
  parameter int DEPTH = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  word_t       in0,
  input  word_t       in1,
  input  word_t       in2,
  input  word_t       in3,
  input  logic [3:0]  ready,
  input  logic [3:0]  done,
  output word_t       outData,
  output logic [3:0]  recv,
`ifdef T30_LEVEL_EN
  output logic [3:0]  send,
  output logic [3:0]  level
`else
  output logic [3:0]  send
`endif
);

  t30_state_t state_q, state_d;
  port_idx_t  ptr_q, ptr_d;
  word_t      outdata_q, outdata_d;
  logic [3:0] send_q, send_d;
  logic [3:0] recv_q, recv_d;

  word_t      in_w [NUM_PORTS];
  logic [3:0] eligible;
  logic       push_go, pop_go, not_full;
  port_idx_t  push_idx;
  word_t      top_next;
  cnt_t       count, count_next;
  word_t      top, below;

  assign in_w[0] = in0;
  assign in_w[1] = in1;
  assign in_w[2] = in2;
  assign in_w[3] = in3;

  stack_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_go),
    .pop   (pop_go),
    .wdata (in_w[push_idx]),
    .count (count),
    .top   (top),
    .below (below)
  );

  // Push arbitration and pop commit; a pop in CHECK frees a slot for a
  // same-cycle push even when the stack is full.
  always_comb begin
    pop_go   = (state_q == CHECK) && done[ptr_q] && (count != '0);
    not_full = (count < cnt_t'(DEPTH)) || pop_go;
    eligible = ready & ~recv_q & {NUM_PORTS{(state_q != OFFER) && not_full}};
    push_go  = |eligible;
    push_idx = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (eligible[i]) push_idx = port_idx_t'(i);
    end
    count_next = count;
    if (push_go && !pop_go) count_next = count + cnt_t'(1);
    if (pop_go && !push_go) count_next = count - cnt_t'(1);
    // Top as it will be after this edge; this is what an offer shows.
    if (push_go)     top_next = in_w[push_idx];
    else if (pop_go) top_next = below;
    else             top_next = top;
  end

  // Pop FSM and registered port outputs.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE:    if (count != '0) state_d = OFFER;
      OFFER:   state_d = CHECK;
      CHECK: begin
        ptr_d   = port_idx_t'(ptr_q + 2'd1);
        state_d = (count_next != '0) ? OFFER : IDLE;
      end
      default: state_d = IDLE;
    endcase
    send_d    = (state_d == OFFER) ? onehot(ptr_d) : 4'b0000;
    outdata_d = (state_d == OFFER) ? top_next : outdata_q;
    recv_d    = push_go ? onehot(push_idx) : 4'b0000;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      outdata_q <= '0;
      send_q    <= '0;
      recv_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      outdata_q <= outdata_d;
      send_q    <= send_d;
      recv_q    <= recv_d;
    end
  end

  assign outData = outdata_q;
  assign send    = send_q;
  assign recv    = recv_q;
`ifdef T30_LEVEL_EN
  assign level   = count;
`endif

endmodule
